// File: rtl/ped_request_ctrl_if.sv
// Pedestrian request handshake bundle.
//   btn_n       : raw pushbutton, active-low, asynchronous and bouncing
//   req_ack     : one-cycle pulse from the light controller when the request is served
//   req         : level request to the light controller
//   btn_press   : one-cycle pulse per clean press
//   busy        : high while the post-service lockout runs
//   lock_remain : whole seconds of lockout remaining (countdown display)
// slave  : the request controller side
// master : the environment side (button + light controller)
interface ped_request_ctrl_if;
  logic       btn_n;
  logic       req_ack;
  logic       req;
  logic       btn_press;
  logic       busy;
  logic [5:0] lock_remain;

  modport slave (
    input  btn_n,
    input  req_ack,
    output req,
    output btn_press,
    output busy,
    output lock_remain
  );

  modport master (
    output btn_n,
    output req_ack,
    input  req,
    input  btn_press,
    input  busy,
    input  lock_remain
  );
endinterface

// File: rtl/ped_request_ctrl.sv
// Pedestrian request controller: synchronizes and debounces the pushbutton, raises a level
// request to the light controller, and after service optionally holds off new requests for a
// fixed lockout with a seconds countdown.
// Ports:
//   clk : sole clock, rising edge
//   rst : synchronous active-high reset
//   bus : ped_request_ctrl_if.slave (btn_n, req_ack in; req, btn_press, busy, lock_remain out)
// Build option: define PED_LOCKOUT_EN to include the LOCKOUT state, the 1 s prescaler and the
// countdown. Without it req_ack returns PENDING straight to IDLE and busy/lock_remain are 0.
module ped_request_ctrl #(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LOCKOUT_S   = 10
) (
  input logic               clk,
  input logic               rst,
  ped_request_ctrl_if.slave bus
);

  localparam int unsigned DebCycles = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int unsigned DebW      = (DebCycles > 1) ? $clog2(DebCycles) : 1;
  localparam logic [DebW-1:0] DebLast = DebW'(DebCycles - 1);

  if (DebCycles < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (LOCKOUT_S < 1 || LOCKOUT_S > 63) begin : g_bad_lockout
    $error("LOCKOUT_S must be in 1..63");
  end

  // ---------------------------------------------------------------------------
  // Synchronizer and debouncer
  // ---------------------------------------------------------------------------
  logic            sync1_q;
  logic            sync2_q;
  logic            btn_stable_q;
  logic            btn_press_q;
  logic [DebW-1:0] deb_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      btn_stable_q <= 1'b1;
      btn_press_q  <= 1'b0;
      deb_cnt_q    <= '0;
    end else begin
      sync1_q     <= bus.btn_n;
      sync2_q     <= sync1_q;
      btn_press_q <= 1'b0;
      if (sync2_q == btn_stable_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DebLast) begin
        deb_cnt_q    <= '0;
        btn_stable_q <= sync2_q;
        // Only the 1->0 flip (press) pulses; a release flips from 0 and yields 0.
        btn_press_q  <= btn_stable_q;
      end else begin
        deb_cnt_q <= deb_cnt_q + 1'b1;
      end
    end
  end

  assign bus.btn_press = btn_press_q;

  // ---------------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {StIdle, StPending, StLockout} state_e;

  state_e state_q;
  logic   req_q;

`ifdef PED_LOCKOUT_EN
  localparam int unsigned PreW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(CLK_FREQ - 1);

  logic [PreW-1:0] presc_q;
  logic [5:0]      lock_remain_q;
  logic            busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      req_q         <= 1'b0;
      busy_q        <= 1'b0;
      presc_q       <= '0;
      lock_remain_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (btn_press_q) begin
            state_q <= StPending;
            req_q   <= 1'b1;
          end
        end
        StPending: begin
          if (bus.req_ack) begin
            state_q       <= StLockout;
            req_q         <= 1'b0;
            busy_q        <= 1'b1;
            presc_q       <= '0;
            lock_remain_q <= 6'(LOCKOUT_S);
          end
        end
        StLockout: begin
          // Presses and acks are ignored here, even one landing on the expiry edge.
          if (presc_q == PreLast) begin
            presc_q <= '0;
            if (lock_remain_q == 6'd1) begin
              state_q       <= StIdle;
              busy_q        <= 1'b0;
              lock_remain_q <= '0;
            end else begin
              lock_remain_q <= lock_remain_q - 6'd1;
            end
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end
        default: begin
          state_q       <= StIdle;
          req_q         <= 1'b0;
          busy_q        <= 1'b0;
          lock_remain_q <= '0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.lock_remain = lock_remain_q;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (btn_press_q) begin
            state_q <= StPending;
            req_q   <= 1'b1;
          end
        end
        StPending: begin
          if (bus.req_ack) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // Lockout length has no meaning in this build.
  logic unused_lockout_s;
  assign unused_lockout_s = ^6'(LOCKOUT_S);

  assign bus.busy        = 1'b0;
  assign bus.lock_remain = 6'd0;
`endif

  assign bus.req = req_q;

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Bench for ped_request_ctrl at CLK_FREQ=1000, DEBOUNCE_MS=5, LOCKOUT_S=3. Covers both builds
// (PED_LOCKOUT_EN defined or not): a vector table for the basic press/ack flow, directed
// sequences for bounce rejection, lockout timing, reset abandonment and the no-lockout build,
// then random stimulus compared each cycle against a behavioural reference model.
module tb_ped_request_ctrl;

  localparam int CLK_FREQ_P = 1000;
  localparam int DEB_MS_P   = 5;
  localparam int LOCK_S_P   = 3;
  localparam int DEB        = CLK_FREQ_P / 1000 * DEB_MS_P;
`ifdef PED_LOCKOUT_EN
  localparam bit LK = 1'b1;
`else
  localparam bit LK = 1'b0;
`endif

  logic clk;
  logic rst;
  ped_request_ctrl_if bus_if ();

  ped_request_ctrl #(
    .CLK_FREQ   (CLK_FREQ_P),
    .DEBOUNCE_MS(DEB_MS_P),
    .LOCKOUT_S  (LOCK_S_P)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Apply inputs for one rising edge, return at the following falling edge.
  task automatic step(input bit r, input bit b, input bit a);
    rst           = r;
    bus_if.btn_n   = b;
    bus_if.req_ack = a;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the button counts as pressed/released once DEB consecutive
  // synchronized samples (two edges old) oppose the current debounced level. The
  // lockout is tracked as elapsed edges since entry.
  // ---------------------------------------------------------------------------
  int m_state;  // 0 idle, 1 pending, 2 lockout
  bit m_stable;
  bit m_press;
  int m_t;
  int m_lock_start;
  bit hist[$];

  function automatic void model_reset();
    m_state      = 0;
    m_stable     = 1'b1;
    m_press      = 1'b0;
    m_t          = 0;
    m_lock_start = 0;
    hist.delete();
    for (int i = 0; i < DEB + 2; i++) hist.push_back(1'b1);
  endfunction

  function automatic void model_edge(input bit r, input bit b, input bit a);
    bit flip;
    bit old_press;
    if (r) begin
      model_reset();
      return;
    end
    m_t++;
    hist.push_back(b);
    void'(hist.pop_front());
    flip = 1'b1;
    for (int j = 0; j < DEB; j++) begin
      if (hist[hist.size() - 3 - j] == m_stable) flip = 1'b0;
    end
    old_press = m_press;
    case (m_state)
      0: if (old_press) m_state = 1;
      1: if (a) begin
        if (LK) begin
          m_state      = 2;
          m_lock_start = m_t;
        end else begin
          m_state = 0;
        end
      end
      2: if (m_t - m_lock_start == LOCK_S_P * CLK_FREQ_P) m_state = 0;
      default: m_state = 0;
    endcase
    m_press = flip && m_stable;
    if (flip) m_stable = !m_stable;
  endfunction

  function automatic int m_remain();
    if (m_state == 2) return LOCK_S_P - (m_t - m_lock_start) / CLK_FREQ_P;
    return 0;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_edge(rst, bus_if.btn_n, bus_if.req_ack);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  typedef struct {
    bit rst;
    bit btn_n;
    bit ack;
    bit req;
    bit press;
    bit busy;
    int remain;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int press_cnt;
    int req_seen;
    int busy_seen;
    bit b;
    bit lvl;
    bit r;
    bit a;
    int run_left;

    // rst, btn_n, ack -> req, press, busy, remain (after that edge)
    vecs[0]  = '{1, 1, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 1, 0, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 0};  // E1
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 0};
    vecs[4]  = '{0, 0, 0, 0, 0, 0, 0};
    vecs[5]  = '{0, 0, 0, 0, 0, 0, 0};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 0};  // E6
    vecs[8]  = '{0, 0, 0, 0, 1, 0, 0};  // E7: press pulse
    vecs[9]  = '{0, 0, 0, 1, 0, 0, 0};  // E8: req up
    vecs[10] = '{0, 0, 0, 1, 0, 0, 0};
    vecs[11] = '{0, 0, 1, 0, 0, LK, LK ? LOCK_S_P : 0};
    vecs[12] = '{0, 1, 0, 0, 0, LK, LK ? LOCK_S_P : 0};

    rst            = 1'b1;
    bus_if.btn_n   = 1'b1;
    bus_if.req_ack = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].rst, vecs[i].btn_n, vecs[i].ack);
      check($sformatf("vec%0d_req", i), bus_if.req, vecs[i].req);
      check($sformatf("vec%0d_press", i), bus_if.btn_press, vecs[i].press);
      check($sformatf("vec%0d_busy", i), bus_if.busy, vecs[i].busy);
      check($sformatf("vec%0d_remain", i), bus_if.lock_remain, vecs[i].remain);
    end

    // Bounce: 3-cycle runs never survive the 5-cycle window.
    reset_dut();
    press_cnt = 0;
    req_seen  = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, ((i / 3) % 2) != 0, 1'b0);
      press_cnt += bus_if.btn_press;
      req_seen  |= bus_if.req;
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0);
      press_cnt += bus_if.btn_press;
      req_seen  |= bus_if.req;
    end
    check("bounce_no_press", press_cnt, 0);
    check("bounce_no_req", req_seen, 0);

`ifdef PED_LOCKOUT_EN
    // Lockout timing, press during lockout, press landing on the expiry edge.
    reset_dut();
    repeat (8) step(1'b0, 1'b0, 1'b0);
    check("lk_pend_req", bus_if.req, 1);
    repeat (8) step(1'b0, 1'b1, 1'b0);
    check("lk_release_req", bus_if.req, 1);
    step(1'b0, 1'b1, 1'b1);
    check("lk_entry_req", bus_if.req, 0);
    check("lk_entry_busy", bus_if.busy, 1);
    check("lk_entry_remain", bus_if.lock_remain, 3);
    press_cnt = 0;
    req_seen  = 0;
    for (int k = 1; k <= 3001; k++) begin
      b = !((k >= 1100 && k < 1120) || k >= 2993);
      step(1'b0, b, 1'b0);
      press_cnt += bus_if.btn_press;
      req_seen  |= bus_if.req;
      if (k == 999) check("lk_999_remain", bus_if.lock_remain, 3);
      if (k == 1000) begin
        check("lk_1000_remain", bus_if.lock_remain, 2);
        check("lk_1000_busy", bus_if.busy, 1);
      end
      if (k == 2000) check("lk_2000_remain", bus_if.lock_remain, 1);
      if (k == 2999) begin
        check("lk_2999_busy", bus_if.busy, 1);
        check("lk_2999_remain", bus_if.lock_remain, 1);
      end
      if (k == 3000) begin
        check("lk_3000_busy", bus_if.busy, 0);
        check("lk_3000_remain", bus_if.lock_remain, 0);
      end
    end
    check("lk_press_pulses", press_cnt, 2);
    check("lk_req_never", req_seen, 0);
    repeat (8) step(1'b0, 1'b1, 1'b0);
`else
    // No lockout: ack returns straight to idle and a new press is accepted.
    reset_dut();
    busy_seen = 0;
    repeat (8) step(1'b0, 1'b0, 1'b0);
    check("nl_pend_req", bus_if.req, 1);
    repeat (8) begin
      step(1'b0, 1'b1, 1'b0);
      busy_seen |= bus_if.busy;
    end
    step(1'b0, 1'b1, 1'b1);
    check("nl_ack_req", bus_if.req, 0);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    check("nl_idle_req", bus_if.req, 0);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b0, 1'b0);
      busy_seen |= bus_if.busy;
      if (k == 7) check("nl_second_e7_req", bus_if.req, 0);
      if (k == 8) check("nl_second_e8_req", bus_if.req, 1);
    end
    check("nl_busy_never", busy_seen, 0);
    repeat (8) step(1'b0, 1'b1, 1'b0);
`endif

    // Reset mid-PENDING with the button held: request abandoned, then re-debounced.
    reset_dut();
    repeat (8) step(1'b0, 1'b0, 1'b0);
    check("rst_pend_req", bus_if.req, 1);
    step(1'b1, 1'b0, 1'b0);
    check("rst_req", bus_if.req, 0);
    check("rst_busy", bus_if.busy, 0);
    check("rst_remain", bus_if.lock_remain, 0);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b0, 1'b0);
      if (k == 7) check("rst_e7_req", bus_if.req, 0);
      if (k == 8) check("rst_e8_req", bus_if.req, 1);
    end

    // Random stimulus against the reference model.
    reset_dut();
    lvl      = 1'b1;
    run_left = 0;
    for (int c = 0; c < 6000; c++) begin
      if (run_left == 0) begin
        lvl      = !lvl;
        run_left = $urandom_range(1, 12);
      end
      run_left--;
      r = ($urandom_range(0, 799) == 0);
      a = ($urandom_range(0, 9) == 0);
      step(r, lvl, a);
      check($sformatf("rnd%0d_req", c), bus_if.req, int'(m_state == 1));
      check($sformatf("rnd%0d_press", c), bus_if.btn_press, m_press);
      check($sformatf("rnd%0d_busy", c), bus_if.busy, int'(m_state == 2));
      check($sformatf("rnd%0d_remain", c), bus_if.lock_remain, m_remain());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
